// File: rtl/weight_ram_loader.sv
// Weight RAM writer: streams DATA_W words into consecutive RAM addresses in layer/unit/input order.
// Optional running checksum of accepted words is built when WEIGHT_CHECKSUM_EN is defined.
module weight_ram_loader #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 10,
    parameter int NUM_LAYERS = 4,
    parameter int NUM_UNITS  = 4,
    parameter int NUM_INPUTS = 4,
    parameter int BASE_ADDR  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              load_abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    output logic              busy,
    output logic              done,
`ifdef WEIGHT_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    output logic [1:0]        dbg_state
);

    localparam int TOTAL = NUM_LAYERS * NUM_UNITS * NUM_INPUTS;
    localparam int IW    = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int UW    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int LW    = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

    localparam logic [IW-1:0] IN_LAST    = IW'(NUM_INPUTS - 1);
    localparam logic [UW-1:0] UNIT_LAST  = UW'(NUM_UNITS - 1);
    localparam logic [LW-1:0] LAYER_LAST = LW'(NUM_LAYERS - 1);

    // The whole image must fit in the RAM address space.
    if (longint'(BASE_ADDR) + longint'(TOTAL) - 1 > (longint'(1) << ADDR_W) - 1) begin : g_bad_params
        $error("weight_ram_loader: BASE_ADDR + TOTAL - 1 exceeds the ADDR_W address range");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     in_q, in_d;
    logic [UW-1:0]     unit_q, unit_d;
    logic [LW-1:0]     layer_q, layer_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_din_q, ram_din_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] cur_addr;
    logic              xfer;
    logic              last_word;
    logic              start_ok;

    // Handshake: a word is transferred on a rising edge where in_valid and in_ready are both high;
    // in_ready depends only on state, never on in_valid.
    assign in_ready  = (state_q == S_LOAD);
    assign busy      = (state_q == S_LOAD);
    assign done      = (state_q == S_DONE);
    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;
    assign ram_we    = ram_we_q;
    assign dbg_state = state_q;

    assign xfer      = in_valid && (state_q == S_LOAD);
    assign start_ok  = (state_q == S_IDLE) && load_start && !load_abort;
    assign last_word = (in_q == IN_LAST) && (unit_q == UNIT_LAST) && (layer_q == LAYER_LAST);
    assign cur_addr  = ADDR_W'(BASE_ADDR)
                     + ADDR_W'(layer_q) * ADDR_W'(NUM_UNITS * NUM_INPUTS)
                     + ADDR_W'(unit_q) * ADDR_W'(NUM_INPUTS)
                     + ADDR_W'(in_q);

    always_comb begin
        state_d    = state_q;
        in_d       = in_q;
        unit_d     = unit_q;
        layer_d    = layer_q;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_LOAD;
                    in_d    = '0;
                    unit_d  = '0;
                    layer_d = '0;
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    ram_we_d   = 1'b1;
                    ram_addr_d = cur_addr;
                    ram_din_d  = in_data;
                    if (in_q == IN_LAST) begin
                        in_d = '0;
                        if (unit_q == UNIT_LAST) begin
                            unit_d  = '0;
                            layer_d = (layer_q == LAYER_LAST) ? '0 : layer_q + 1'b1;
                        end else begin
                            unit_d = unit_q + 1'b1;
                        end
                    end else begin
                        in_d = in_q + 1'b1;
                    end
                    if (last_word) begin
                        state_d = S_DONE;
                    end
                end
                // Abort overrides completion; a write captured this cycle still lands.
                if (load_abort) begin
                    state_d = S_IDLE;
                    in_d    = '0;
                    unit_d  = '0;
                    layer_d = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            in_q       <= '0;
            unit_q     <= '0;
            layer_q    <= '0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= ADDR_W'(BASE_ADDR);
            ram_din_q  <= '0;
        end else begin
            state_q    <= state_d;
            in_q       <= in_d;
            unit_q     <= unit_d;
            layer_q    <= layer_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
        end
    end

`ifdef WEIGHT_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (start_ok) begin
            checksum_d = '0;
        end else if (xfer) begin
            checksum_d = checksum_q + in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_weight_ram_loader.sv
// Scoreboard bench for weight_ram_loader: stimulus pushes {done, addr, data} expectations,
// a negedge monitor pops one per ram_we. Define WEIGHT_CHECKSUM_EN to also exercise the checksum.
module tb_weight_ram_loader;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int EW     = 1 + ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              load_start;
  logic              load_abort;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic              ram_we;
  logic              busy;
  logic              done;
  logic [1:0]        dbg_state;
`ifdef WEIGHT_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  logic [EW-1:0]     exp_q[$];
  logic [DATA_W-1:0] sum_model;
  int                n_vec = 0;
  int                n_err = 0;

  weight_ram_loader dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .load_abort (load_abort),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_we     (ram_we),
    .busy       (busy),
    .done       (done),
`ifdef WEIGHT_CHECKSUM_EN
    .checksum   (checksum),
`endif
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got %0d vectors required completion", n_vec);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset) begin
      if (ram_we) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write at %0t",
                   ram_addr, ram_din, $time);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          chk("write{done,addr,data}", {21'd0, done, ram_addr, ram_din}, {21'd0, e});
        end
      end else if (done) begin
        n_vec++;
        n_err++;
        $display("FAIL done_without_write: got done=1 expected 0 at %0t", $time);
      end
    end
  end

  // driver tasks
  task automatic start_load();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    sum_model  = '0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic send(input logic [DATA_W-1:0] data, input int idx, input bit last);
    in_valid = 1'b1;
    in_data  = data;
    chk("in_ready_load", in_ready, 1);
    exp_q.push_back({last, ADDR_W'(idx), data});
    sum_model = sum_model + data;
    @(negedge clk);
  endtask

  task automatic load_all(input logic [DATA_W-1:0] base, input bit ones, input int gap,
                          input int restart_at);
    for (int l = 0; l < 4; l++) begin
      for (int u = 0; u < 4; u++) begin
        for (int i = 0; i < 4; i++) begin
          int idx;
          idx = l * 16 + u * 4 + i;
          if (idx == restart_at) load_start = 1'b1;
          send(ones ? 32'hFFFF_FFFF : base + DATA_W'(idx), idx, idx == 63);
          load_start = 1'b0;
          if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
          end
        end
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    reset      = 1'b0;
    load_start = 1'b0;
    load_abort = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    sum_model  = '0;
    #2;
    chk("rst_ram_we", ram_we, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_din", ram_din, 0);
    chk("rst_state", dbg_state, 0);
`ifdef WEIGHT_CHECKSUM_EN
    chk("rst_checksum", checksum, 0);
`endif
    @(negedge clk);
    reset = 1'b1;

    // reset in the middle of a stream
    start_load();
    for (int i = 0; i < 10; i++) send(32'h300 + i, i, 1'b0);
    in_valid = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("midrst_ram_we", ram_we, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ram_addr", ram_addr, 0);
    chk("midrst_ram_din", ram_din, 0);
    chk("midrst_done", done, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // full back-to-back load, data = idx + 0x100
    start_load();
    load_all(32'h100, 1'b0, 0, -1);
    chk("ready_in_done", in_ready, 0);
`ifdef WEIGHT_CHECKSUM_EN
    chk("checksum_full", checksum, 32'h47E0);
`endif
    @(negedge clk);
    chk("busy_after_done", busy, 0);

    // gapped stream: one valid cycle in three
    start_load();
    load_all(32'h200, 1'b0, 2, -1);
`ifdef WEIGHT_CHECKSUM_EN
    chk("checksum_gapped", checksum, sum_model);
`endif

    // abort with the 20th word accepted in the abort cycle
    start_load();
    for (int i = 0; i < 19; i++) send(32'h500 + i, i, 1'b0);
    load_abort = 1'b1;
    send(32'h500 + 19, 19, 1'b0);
    load_abort = 1'b0;
    in_valid   = 1'b0;
    chk("abort_in_ready", in_ready, 0);
    chk("abort_busy", busy, 0);

    // in_valid in IDLE must not write
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    repeat (5) @(negedge clk);
    chk("idle_in_ready", in_ready, 0);
    in_valid = 1'b0;

    // abort wins over start in IDLE
    load_start = 1'b1;
    load_abort = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    load_abort = 1'b0;
    chk("abort_start_busy", busy, 0);
    chk("abort_start_ready", in_ready, 0);

    // restart after abort; a load_start mid-load must not reset the counters
    start_load();
    load_all(32'h400, 1'b0, 0, 5);
    chk("ready_in_done2", in_ready, 0);
`ifdef WEIGHT_CHECKSUM_EN
    chk("checksum_restart", checksum, 32'h107E0);
`endif
    @(negedge clk);

`ifdef WEIGHT_CHECKSUM_EN
    // all-ones wraps modulo 2^32, then clears on the next accepted start
    start_load();
    load_all(32'h0, 1'b1, 0, -1);
    chk("checksum_ones", checksum, 32'hFFFF_FFC0);
    repeat (3) @(negedge clk);
    chk("checksum_hold", checksum, 32'hFFFF_FFC0);
    start_load();
    chk("checksum_cleared", checksum, 0);
    load_abort = 1'b1;
    @(negedge clk);
    load_abort = 1'b0;
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
